// File: rtl/conv_pkg.sv
// conv_pkg: shared width helpers, saturation bounds and tap-packing convention for conv blocks
package conv_pkg;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
   function automatic int prod_w(input int dw, input int cw);
      return dw + cw;
   endfunction
   function automatic int sum_w(input int pw, input int taps);
      return pw + clog2(taps);
   endfunction
   function automatic longint sat_max(input int acc_w);
      return (longint'(1) <<< (acc_w - 1)) - 1;
   endfunction
   function automatic longint sat_min(input int acc_w);
      return -(longint'(1) <<< (acc_w - 1));
   endfunction
   // tap0 sits in the MSBs of every packed pixel/coefficient bus
   function automatic int tap_lsb(input int tap, input int taps, input int w);
      return (taps - 1 - tap) * w;
   endfunction
endpackage

// File: rtl/conv_tap_tree.sv
// conv_tap_tree: operand register, per-tap multipliers and a two-level pipelined adder tree
module conv_tap_tree
   import conv_pkg::*;
#(
   parameter int TAPS        = 11,
   parameter int DATA_W      = 8,
   parameter int COEF_W      = 8,
   parameter int DATA_SIGNED = 0,
   parameter int SUM_W       = sum_w(prod_w(DATA_W, COEF_W), TAPS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_en,
   input  logic                    i_valid,
   input  logic                    i_first,
   input  logic                    i_last,
   input  logic                    i_relu,
   input  logic [TAPS*DATA_W-1:0]  i_data,
   input  logic [TAPS*COEF_W-1:0]  i_coef,
   output logic                    o_valid,
   output logic                    o_first,
   output logic                    o_last,
   output logic                    o_relu,
   output logic signed [SUM_W-1:0] o_sum
);
   localparam int PROD_W = prod_w(DATA_W, COEF_W);
   localparam int NG     = (TAPS + 3) / 4;

   logic [3:0]               r_v, r_f, r_l, r_r;
   logic [TAPS*DATA_W-1:0]   r_data;
   logic [TAPS*COEF_W-1:0]   r_coef;
   logic signed [PROD_W-1:0] w_px   [TAPS];
   logic signed [PROD_W-1:0] w_cf   [TAPS];
   logic signed [PROD_W-1:0] w_prod [TAPS];
   logic signed [PROD_W-1:0] r_prod [TAPS];
   logic signed [SUM_W-1:0]  w_grp  [NG];
   logic signed [SUM_W-1:0]  r_grp  [NG];
   logic signed [SUM_W-1:0]  w_sum;
   logic signed [SUM_W-1:0]  r_sum;

   // unsigned pixels get a zero MSB so every product is a plain signed multiply
   always_comb begin
      for (int i = 0; i < TAPS; i++) begin
         w_px[i]   = (DATA_SIGNED != 0) ? PROD_W'($signed(r_data[tap_lsb(i, TAPS, DATA_W) +: DATA_W]))
                                        : PROD_W'({1'b0, r_data[tap_lsb(i, TAPS, DATA_W) +: DATA_W]});
         w_cf[i]   = PROD_W'($signed(r_coef[tap_lsb(i, TAPS, COEF_W) +: COEF_W]));
         w_prod[i] = w_px[i] * w_cf[i];
      end
      for (int g = 0; g < NG; g++) w_grp[g] = '0;
      for (int i = 0; i < TAPS; i++) w_grp[i / 4] = w_grp[i / 4] + SUM_W'(r_prod[i]);
      w_sum = '0;
      for (int g = 0; g < NG; g++) w_sum = w_sum + r_grp[g];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v    <= '0;
         r_f    <= '0;
         r_l    <= '0;
         r_r    <= '0;
         r_data <= '0;
         r_coef <= '0;
         r_sum  <= '0;
         for (int i = 0; i < TAPS; i++) r_prod[i] <= '0;
         for (int g = 0; g < NG; g++) r_grp[g] <= '0;
      end else if (i_en) begin
         r_v    <= {r_v[2:0], i_valid};
         r_f    <= {r_f[2:0], i_valid & i_first};
         r_l    <= {r_l[2:0], i_valid & i_last};
         r_r    <= {r_r[2:0], i_valid & i_relu};
         r_data <= i_data;
         r_coef <= i_coef;
         r_sum  <= w_sum;
         for (int i = 0; i < TAPS; i++) r_prod[i] <= w_prod[i];
         for (int g = 0; g < NG; g++) r_grp[g] <= w_grp[g];
      end
   end

   assign o_valid = r_v[3];
   assign o_first = r_f[3];
   assign o_last  = r_l[3];
   assign o_relu  = r_r[3];
   assign o_sum   = r_sum;
endmodule

// File: rtl/conv_col_mac_p.sv
// conv_col_mac_p: windowed column MAC with saturation, optional ReLU and a valid/ready result port
module conv_col_mac_p
   import conv_pkg::*;
#(
   parameter int TAPS        = 11,
   parameter int DATA_W      = 8,
   parameter int COEF_W      = 8,
   parameter int ACC_W       = 23,
   parameter int DATA_SIGNED = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_first,
   input  logic                    in_last,
   input  logic [TAPS*DATA_W-1:0]  in_data,
   input  logic [TAPS*COEF_W-1:0]  in_coef,
   input  logic                    relu_en,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] out_data,
   output logic                    out_sat,
   output logic                    proto_err
);
   localparam int SUM_W = sum_w(prod_w(DATA_W, COEF_W), TAPS);
   localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
   localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

   generate
      if (ACC_W < SUM_W || TAPS < 1 || TAPS > 32) begin : g_bad_cfg
         $error("conv_col_mac_p: TAPS must be 1..32 and ACC_W must cover the adder tree width");
      end
   endgenerate

   logic                    w_en, w_v, w_f, w_l, w_r;
   logic signed [SUM_W-1:0] w_sum;
   logic                    w_start, w_ovf, w_sat_n, w_relu_n;
   logic signed [ACC_W-1:0] w_base, w_acc_n;
   logic signed [ACC_W:0]   w_wide;
   logic                    r_open, r_sat, r_relu;
   logic signed [ACC_W-1:0] r_acc, r_out_data;
   logic                    r_out_valid, r_out_sat, r_proto_err;

   assign w_en     = !r_out_valid || out_ready;
   assign in_ready = w_en;

   conv_tap_tree #(
      .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .DATA_SIGNED(DATA_SIGNED), .SUM_W(SUM_W)
   ) u_tree (
      .clk(clk), .rst_n(rst_n), .i_en(w_en),
      .i_valid(in_valid), .i_first(in_first), .i_last(in_last), .i_relu(relu_en),
      .i_data(in_data), .i_coef(in_coef),
      .o_valid(w_v), .o_first(w_f), .o_last(w_l), .o_relu(w_r), .o_sum(w_sum)
   );

   // an orphan beat (no window open) starts a window just like a first beat
   always_comb begin
      w_start  = w_f || !r_open;
      w_base   = w_start ? '0 : r_acc;
      w_wide   = (ACC_W + 1)'(w_base) + (ACC_W + 1)'(w_sum);
      w_ovf    = w_wide[ACC_W] != w_wide[ACC_W-1];
      w_acc_n  = w_ovf ? (w_wide[ACC_W] ? ACC_MIN : ACC_MAX) : w_wide[ACC_W-1:0];
      w_sat_n  = (!w_start && r_sat) || w_ovf;
      w_relu_n = w_start ? w_r : r_relu;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_open      <= 1'b0;
         r_sat       <= 1'b0;
         r_relu      <= 1'b0;
         r_acc       <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_sat   <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         r_proto_err <= w_en && w_v && (w_f == r_open);
         if (w_en) begin
            r_out_valid <= w_v && w_l;
            if (w_v && w_l) begin
               r_out_data <= (w_relu_n && w_acc_n[ACC_W-1]) ? '0 : w_acc_n;
               r_out_sat  <= w_sat_n;
               r_acc      <= '0;
               r_sat      <= 1'b0;
               r_relu     <= 1'b0;
               r_open     <= 1'b0;
            end else if (w_v) begin
               r_acc  <= w_acc_n;
               r_sat  <= w_sat_n;
               r_relu <= w_relu_n;
               r_open <= 1'b1;
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sat   = r_out_sat;
   assign proto_err = r_proto_err;
endmodule
